// File: rtl/alu_div_seq.sv
// Sequential 8-bit unsigned restoring divider that produces one quotient bit per clock over valid/ready handshakes.
// Optional macro ALU_DIV_ZERO_FAST_EN: a zero divisor goes straight to DONE instead of running the 8 steps.
module alu_div_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_dvd;
    logic [7:0] r_div;
    logic [7:0] r_quot;
    logic [7:0] r_prem;
    logic [2:0] r_cnt;
    logic       r_dbz;

    logic [8:0] w_shift;
    logic       w_ge;
    logic [7:0] w_diff;

    // The partial remainder never exceeds 8 bits after a step, so the difference is taken modulo 256.
    assign w_shift = {r_prem, r_dvd[7]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[7:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_DIV_ZERO_FAST_EN
                    w_next = (b == 8'd0) ? DONE : CALC;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC: begin
                if (r_cnt == 3'd7) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= 8'd0;
            r_div  <= 8'd0;
            r_quot <= 8'd0;
            r_prem <= 8'd0;
            r_cnt  <= 3'd0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvd  <= a;
                        r_div  <= b;
                        r_quot <= 8'd0;
                        r_prem <= 8'd0;
                        r_cnt  <= 3'd0;
                        r_dbz  <= (b == 8'd0);
`ifdef ALU_DIV_ZERO_FAST_EN
                        if (b == 8'd0) begin
                            r_quot <= 8'hFF;
                            r_prem <= a;
                        end
`endif
                    end
                end
                CALC: begin
                    r_prem <= w_ge ? w_diff : w_shift[7:0];
                    r_quot <= {r_quot[6:0], w_ge};
                    r_dvd  <= {r_dvd[6:0], 1'b0};
                    r_cnt  <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_prem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: vector table, backpressure, mid-operation reset and back-to-back issue.
module tb_alu_div_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    alu_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] eq,
                          input logic [7:0] er, input logic ed, input string nm);
        int lat;
        int exp_lat;
        exp_lat  = (FAST && tb_v == 8'd0) ? 0 : 8;
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = 8'h5A;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_quotient"}, int'(quotient), int'(eq));
        chk({nm, "_remainder"}, int'(remainder), int'(er));
        chk({nm, "_dbz"}, int'(div_by_zero), int'(ed));
        chk({nm, "_in_ready_done"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_in_ready_after"}, int'(in_ready), 1);
        chk({nm, "_out_valid_after"}, int'(out_valid), 0);
    endtask

    initial begin
        int bad;
        logic [7:0] ba[50];
        logic [7:0] bb[50];

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd5,   8'd10,  8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd0,   8'd255, 8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[6] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
        vecs[7] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low and in_valid is ignored.
        a = 8'd37; b = 8'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bad = 0;
        while (!out_valid && bad < 20) begin
            @(posedge clk); #1;
            bad++;
        end
        chk("bp_latency", bad, 8);
        a = 8'd1; b = 8'd1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_q", k), int'(quotient), 6);
            chk($sformatf("bp_hold%0d_r", k), int'(remainder), 1);
            chk($sformatf("bp_hold%0d_in_ready", k), int'(in_ready), 0);
            chk($sformatf("bp_hold%0d_out_valid", k), int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("bp_no_late_accept", int'(in_ready), 1);

        // Reset after the 4th CALC edge aborts the operation.
        a = 8'd200; b = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("abort_no_out_valid", bad, 0);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, "after_abort");

        // Back-to-back issue: accepts expected at cycles 0,10,20,...
        for (int c = 0; c < 50; c++) begin
            ba[c] = 8'((c * 37 + 11) % 256);
            bb[c] = 8'((c % 7) + 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            a = ba[c]; b = bb[c]; in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b_c%0d_in_ready", c), int'(in_ready), (c % 10 == 9) ? 1 : 0);
            chk($sformatf("b2b_c%0d_out_valid", c), int'(out_valid), (c % 10 == 8) ? 1 : 0);
            if (c % 10 == 8) begin
                chk($sformatf("b2b_c%0d_q", c), int'(quotient), int'(ba[c-8]) / int'(bb[c-8]));
                chk($sformatf("b2b_c%0d_r", c), int'(remainder), int'(ba[c-8]) % int'(bb[c-8]));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
